// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants for the pipeline decode/hazard control path
// Purpose: opcode constants, ID/EX control-word bit indices and the hazard FSM
//          state encoding shared by hazard_detect and hazard_ctrl.
// Ports:   none (package).
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  localparam int CTR_W        = 9;
  localparam int CTR_REGDST   = 8;
  localparam int CTR_ALUOP_HI = 7;
  localparam int CTR_ALUOP_LO = 6;
  localparam int CTR_ALUSRC   = 5;
  localparam int CTR_BRANCH   = 4;
  localparam int CTR_MEMREAD  = 3;
  localparam int CTR_MEMWRITE = 2;
  localparam int CTR_REGWRITE = 1;
  localparam int CTR_MEMTOREG = 0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_e;

  // Only R-type, sw and beq read rt as a source operand.
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  // Everything except the NOP encoding reads rs.
  function automatic logic op_uses_rs(input logic [5:0] op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detection
// Purpose: decodes which source registers the IF/ID instruction reads and
//          compares them against the load destination held in ID/EX.
// Ports:   id_opcode_i/id_rs_i/id_rt_i  IF/ID instruction fields
//          ex_memread_i, ex_rt_i        ID/EX load flag and destination
//          hazard_o                     load-use hazard present this cycle
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] id_opcode_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rt_i,
  output logic       hazard_o
);

  logic use_rs;
  logic use_rt;

  assign use_rs = op_uses_rs(id_opcode_i);
  assign use_rt = op_uses_rt(id_opcode_i);

  // $zero is never a real dependency, even if a load targets it.
  assign hazard_o = ex_memread_i && (ex_rt_i != 5'd0) &&
                    ((use_rs && (ex_rt_i == id_rs_i)) ||
                     (use_rt && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall and branch flush controller
// Purpose: stalls PC and IF/ID and bubbles ID/EX on a load-use hazard for
//          LOAD_DELAY cycles; flushes younger stages on a taken branch in MEM.
//          Optional perf counters are built only with HAZARD_PERF_EN defined.
// Ports:   clk, rst (sync, active-high)
//          id_opcode/id_rs/id_rt, ex_ctr_bits/ex_rt, mem_branch_taken  inputs
//          pc_write, if_id_write, ctr_zero                             stall controls
//          if_id_flush, id_ex_flush, ex_mem_flush                      flush controls
//          stall_active                                                registered STALL flag
//          stall_count, flush_count                                    perf counters
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_DELAY = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [8:0]       ex_ctr_bits,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             ctr_zero,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int SCW = $clog2(LOAD_DELAY + 1);

  hz_state_e      state_q, state_d;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
  logic           hazard;
  logic           unused_ctr;

  // Only MemRead matters for hazard detection.
  assign unused_ctr = ^{ex_ctr_bits[8:4], ex_ctr_bits[2:0]};

  hazard_detect u_detect (
    .id_opcode_i  (id_opcode),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .ex_memread_i (ex_ctr_bits[CTR_MEMREAD]),
    .ex_rt_i      (ex_rt),
    .hazard_o     (hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    ctr_zero     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!rst) begin
      if (mem_branch_taken) begin
        // A taken branch wins over any stall: the stalled instruction is squashed anyway.
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        state_d      = ST_RUN;
        stall_cnt_d  = '0;
      end else if (state_q == ST_STALL) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        ctr_zero    = 1'b1;
        stall_cnt_d = stall_cnt_q - SCW'(1);
        if (stall_cnt_q == SCW'(1)) begin
          state_d = ST_RUN;
        end
      end else if (hazard) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        ctr_zero    = 1'b1;
        // The detecting cycle is the first stall cycle; STALL covers the rest.
        if (LOAD_DELAY > 1) begin
          state_d     = ST_STALL;
          stall_cnt_d = SCW'(LOAD_DELAY - 1);
        end
      end
    end
  end

  assign stall_active = (state_q == ST_STALL);

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (!pc_write && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
      if (mem_branch_taken && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (LOAD_DELAY 1 and 3)
module tb_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam logic [6:0] V_IDLE  = 7'b1100000;
  localparam logic [6:0] V_STALL = 7'b0010000;
  localparam logic [6:0] V_FLUSH = 7'b1101110;

`ifdef HAZARD_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [5:0] id_opcode;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [8:0] ex_ctr_bits;
  logic [4:0] ex_rt;
  logic       mem_branch_taken;

  logic pw1, iw1, cz1, iff1, ief1, emf1, sa1;
  logic pw3, iw3, cz3, iff3, ief3, emf3, sa3;
  logic [CNT_W-1:0] sc1, fc1, sc3, fc3;
  logic [6:0] o1, o3;

  int errors = 0;
  int checks = 0;

  // Reference state: remaining stall cycles after the current one, and perf totals.
  int left1 = 0, left3 = 0;
  int msc1 = 0, mfc1 = 0, msc3 = 0, mfc3 = 0;

  hazard_ctrl #(.LOAD_DELAY(1), .CNT_W(CNT_W)) u_ld1 (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_ctr_bits(ex_ctr_bits), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .pc_write(pw1), .if_id_write(iw1), .ctr_zero(cz1), .if_id_flush(iff1),
    .id_ex_flush(ief1), .ex_mem_flush(emf1), .stall_active(sa1),
    .stall_count(sc1), .flush_count(fc1)
  );

  hazard_ctrl #(.LOAD_DELAY(3), .CNT_W(CNT_W)) u_ld3 (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_ctr_bits(ex_ctr_bits), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .pc_write(pw3), .if_id_write(iw3), .ctr_zero(cz3), .if_id_flush(iff3),
    .id_ex_flush(ief3), .ex_mem_flush(emf3), .stall_active(sa3),
    .stall_count(sc3), .flush_count(fc3)
  );

  assign o1 = {pw1, iw1, cz1, iff1, ief1, emf1, sa1};
  assign o3 = {pw3, iw3, cz3, iff3, ief3, emf3, sa3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_hazard(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [8:0] ctr,
                                      input logic [4:0] ert);
    logic urs, urt;
    urs = (op != 6'b100000);
    urt = (op == 6'b000000) || (op == 6'b101011) || (op == 6'b000100);
    return ctr[3] && (ert != 0) && ((urs && ert == rs) || (urt && ert == rt));
  endfunction

  function automatic logic [6:0] ref_out(input int left, input logic hz,
                                         input logic br, input logic r);
    logic [6:0] v;
    v = V_IDLE;
    if (!r) begin
      if (br) v = V_FLUSH;
      else if (left > 0 || hz) v = V_STALL;
    end
    v[0] = (left > 0);
    return v;
  endfunction

  function automatic int ref_next(input int left, input int ld, input logic hz,
                                  input logic br, input logic r);
    if (r || br) return 0;
    if (left > 0) return left - 1;
    if (hz) return ld - 1;
    return 0;
  endfunction

  function automatic int sat_inc(input int v, input logic en);
    if (en && v < (2 ** CNT_W) - 1) return v + 1;
    return v;
  endfunction

  function automatic logic [6:0] exp1();
    return ref_out(left1, ref_hazard(id_opcode, id_rs, id_rt, ex_ctr_bits, ex_rt),
                   mem_branch_taken, rst);
  endfunction

  function automatic logic [6:0] exp3();
    return ref_out(left3, ref_hazard(id_opcode, id_rs, id_rt, ex_ctr_bits, ex_rt),
                   mem_branch_taken, rst);
  endfunction

  // Advances the reference model across one rising edge; entered mid-cycle, leaves at edge+1.
  task automatic tick();
    logic hz;
    logic [6:0] e1, e3;
    int n1, n3;
    hz = ref_hazard(id_opcode, id_rs, id_rt, ex_ctr_bits, ex_rt);
    e1 = ref_out(left1, hz, mem_branch_taken, rst);
    e3 = ref_out(left3, hz, mem_branch_taken, rst);
    n1 = ref_next(left1, 1, hz, mem_branch_taken, rst);
    n3 = ref_next(left3, 3, hz, mem_branch_taken, rst);
    @(posedge clk);
    left1 = n1;
    left3 = n3;
    if (rst) begin
      msc1 = 0; mfc1 = 0; msc3 = 0; mfc3 = 0;
    end else begin
      msc1 = sat_inc(msc1, !e1[6]);
      msc3 = sat_inc(msc3, !e3[6]);
      mfc1 = sat_inc(mfc1, mem_branch_taken);
      mfc3 = sat_inc(mfc3, mem_branch_taken);
    end
    #1;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [8:0] ctr, input logic [4:0] ert, input logic br);
    id_opcode = op; id_rs = rs; id_rt = rt;
    ex_ctr_bits = ctr; ex_rt = ert; mem_branch_taken = br;
  endtask

  task automatic idle_cycles(input int n);
    set_in(6'b100000, 5'd0, 5'd0, 9'd0, 5'd0, 1'b0);
    for (int i = 0; i < n; i++) begin
      #4;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(2);
    #4;
    checks++;
    if (o1 !== V_IDLE) begin
      $display("FAIL reset_ld1 got=%b want=%b", o1, V_IDLE); errors++;
    end
    checks++;
    if (o3 !== V_IDLE) begin
      $display("FAIL reset_ld3 got=%b want=%b", o3, V_IDLE); errors++;
    end
    checks++;
    if ({sc1, fc1, sc3, fc3} !== '0) begin
      $display("FAIL reset_counters got=%0d/%0d/%0d/%0d want=0", sc1, fc1, sc3, fc3); errors++;
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    set_in(6'b000000, 5'd8, 5'd0, 9'b000101011, 5'd8, 1'b0);
    #4;
    checks++;
    if (o1 !== V_STALL) begin
      $display("FAIL load_use_stall got=%b want=%b", o1, V_STALL); errors++;
    end
    tick();
    set_in(6'b100000, 5'd0, 5'd0, 9'd0, 5'd0, 1'b0);
    #4;
    checks++;
    if (o1 !== V_IDLE) begin
      $display("FAIL load_use_release got=%b want=%b", o1, V_IDLE); errors++;
    end
    tick();
    idle_cycles(3);
  endtask

  task automatic test_rs_only();
    set_in(6'b100011, 5'd3, 5'd8, 9'b000101011, 5'd8, 1'b0);
    #4;
    checks++;
    if (o1 !== V_IDLE || o3 !== V_IDLE) begin
      $display("FAIL lw_rt_no_stall got=%b/%b want=%b", o1, o3, V_IDLE); errors++;
    end
    tick();
  endtask

  task automatic test_zero_reg();
    set_in(6'b000000, 5'd0, 5'd0, 9'b000101011, 5'd0, 1'b0);
    #4;
    checks++;
    if (o1 !== V_IDLE || o3 !== V_IDLE) begin
      $display("FAIL zero_reg_no_stall got=%b/%b want=%b", o1, o3, V_IDLE); errors++;
    end
    tick();
  endtask

  task automatic test_branch();
    set_in(6'b000000, 5'd8, 5'd0, 9'b000101011, 5'd8, 1'b1);
    #4;
    checks++;
    if (o1 !== V_FLUSH || o3 !== V_FLUSH) begin
      $display("FAIL branch_beats_hazard got=%b/%b want=%b", o1, o3, V_FLUSH); errors++;
    end
    tick();
    mem_branch_taken = 1'b0;
    #4;
    checks++;
    if (o3 !== V_STALL) begin
      $display("FAIL branch_then_stall got=%b want=%b", o3, V_STALL); errors++;
    end
    tick();
    ex_ctr_bits = 9'd0;
    #4;
    checks++;
    if (o3 !== (V_STALL | 7'b1)) begin
      $display("FAIL stall_cycle2 got=%b want=%b", o3, V_STALL | 7'b1); errors++;
    end
    tick();
    mem_branch_taken = 1'b1;
    #4;
    checks++;
    if (o3 !== (V_FLUSH | 7'b1)) begin
      $display("FAIL branch_mid_stall got=%b want=%b", o3, V_FLUSH | 7'b1); errors++;
    end
    tick();
    mem_branch_taken = 1'b0;
    #4;
    checks++;
    if (o3 !== V_IDLE || o1 !== V_IDLE) begin
      $display("FAIL after_branch_idle got=%b/%b want=%b", o1, o3, V_IDLE); errors++;
    end
    tick();
  endtask

  task automatic test_perf(input string tag);
    checks++;
    if (sc1 !== CNT_W'(PERF_ON ? msc1 : 0) || fc1 !== CNT_W'(PERF_ON ? mfc1 : 0)) begin
      $display("FAIL perf_ld1_%s got=%0d/%0d want=%0d/%0d", tag, sc1, fc1,
               PERF_ON ? msc1 : 0, PERF_ON ? mfc1 : 0); errors++;
    end
    checks++;
    if (sc3 !== CNT_W'(PERF_ON ? msc3 : 0) || fc3 !== CNT_W'(PERF_ON ? mfc3 : 0)) begin
      $display("FAIL perf_ld3_%s got=%0d/%0d want=%0d/%0d", tag, sc3, fc3,
               PERF_ON ? msc3 : 0, PERF_ON ? mfc3 : 0); errors++;
    end
  endtask

  task automatic test_long_stall();
    int n_stall;
    int n_active;
    n_stall = 0;
    n_active = 0;
    set_in(6'b000000, 5'd8, 5'd0, 9'b000101011, 5'd8, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      #4;
      if (!pw3) n_stall++;
      if (sa3 && c >= 2 && c <= 3) n_active++;
      if (sa3 && (c < 2 || c > 3)) n_active += 100;
      tick();
      ex_ctr_bits = 9'd0;
    end
    checks++;
    if (n_stall != 3) begin
      $display("FAIL long_stall_cycles got=%0d want=3", n_stall); errors++;
    end
    checks++;
    if (n_active != 2) begin
      $display("FAIL long_stall_active got=%0d want=2", n_active); errors++;
    end
  endtask

  task automatic test_reset_mid_stall();
    set_in(6'b101011, 5'd1, 5'd8, 9'b000101011, 5'd8, 1'b0);
    #4;
    tick();
    ex_ctr_bits = 9'd0;
    rst = 1'b1;
    #4;
    checks++;
    if (o3[6:1] !== V_IDLE[6:1]) begin
      $display("FAIL rst_mid_stall_outputs got=%b want=%b", o3[6:1], V_IDLE[6:1]); errors++;
    end
    tick();
    rst = 1'b0;
    #4;
    checks++;
    if (o3 !== V_IDLE) begin
      $display("FAIL rst_mid_stall_after got=%b want=%b", o3, V_IDLE); errors++;
    end
    checks++;
    if ({sc3, fc3} !== '0) begin
      $display("FAIL rst_mid_stall_counters got=%0d/%0d want=0", sc3, fc3); errors++;
    end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] ops [5];
    logic [6:0] e1, e3;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b100000;
    for (int i = 0; i < 400; i++) begin
      id_opcode = ($urandom_range(0, 5) == 5) ? 6'($urandom) : ops[$urandom_range(0, 4)];
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      ex_ctr_bits = 9'($urandom);
      mem_branch_taken = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) == 0);
      #4;
      e1 = exp1();
      e3 = exp3();
      checks++;
      if (o1 !== e1) begin
        $display("FAIL rand_ld1 cyc=%0d got=%b want=%b", i, o1, e1); errors++;
      end
      checks++;
      if (o3 !== e3) begin
        $display("FAIL rand_ld3 cyc=%0d got=%b want=%b", i, o3, e3); errors++;
      end
      tick();
    end
    rst = 1'b0;
    idle_cycles(4);
  endtask

  initial begin
    rst = 1'b1;
    set_in(6'b100000, 5'd0, 5'd0, 9'd0, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_rs_only();
    test_zero_reg();
    test_branch();
    test_perf("case1_5");
    idle_cycles(3);
    test_long_stall();
    test_reset_mid_stall();
    test_random();
    test_perf("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
